// File: rtl/bpfcap_dma_engine.sv
// Capture-copy engine: CSR slave, burst read master, FIFO, burst write master.
// Optional interrupt output is enabled by defining BPFCAP_IRQ_EN.
module bpfcap_dma_engine #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned FIFO_DEPTH = 256,
  parameter int unsigned MAX_BURST  = 16,
  parameter int unsigned BURST_W    = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [2:0]         avs_s0_address,
  input  logic               avs_s0_write,
  input  logic               avs_s0_read,
  input  logic [31:0]        avs_s0_writedata,
  output logic [31:0]        avs_s0_readdata,
  output logic [31:0]        avs_m0_address,
  output logic               avs_m0_read,
  output logic [BURST_W-1:0] avs_m0_burstcount,
  input  logic [DATA_W-1:0]  avs_m0_readdata,
  input  logic               avs_m0_readdatavalid,
  input  logic               avs_m0_waitrequest,
  output logic [31:0]        avs_m1_address,
  output logic               avs_m1_write,
  output logic [DATA_W-1:0]  avs_m1_writedata,
  output logic [BURST_W-1:0] avs_m1_burstcount,
  input  logic               avs_m1_waitrequest,
  output logic               irq
);
  localparam int unsigned BpbLog    = $clog2(DATA_W / 8);
  localparam int unsigned PtrW      = $clog2(FIFO_DEPTH);
  localparam logic [31:0] AlignMask = 32'((DATA_W / 8) - 1);
  localparam logic [PtrW:0] FifoFull = (PtrW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {RdIdle, RdReq, RdData} rd_state_e;
  typedef enum logic [1:0] {WrIdle, WrBurst, WrDone} wr_state_e;

  rd_state_e rd_state_q, rd_state_d;
  wr_state_e wr_state_q, wr_state_d;

  logic [31:0]        src_q, dst_q, len_q, pkt_count_q, readdata_q, csr_rdata;
  logic               busy_q, done_q, err_q, aborted_q, abort_q;
  logic [31:0]        rd_addr_q, rd_left_q, wr_addr_q, wr_left_q;
  logic [BURST_W-1:0] rd_burst_q, rd_pend_q, wr_burst_q, wr_cnt_q;
  logic [BURST_W-1:0] rd_burst_nxt, wr_burst_nxt;
  logic [DATA_W-1:0]  fifo_mem [FIFO_DEPTH];
  logic [PtrW-1:0]    fifo_wptr_q, fifo_rptr_q;
  logic [PtrW:0]      fifo_cnt_q;
  logic csr_ctrl_wr, cfg_wr, start, abort_req, misaligned, rd_credit_ok;
  logic rd_accept, rd_beat, push, pop, beat_acc, last_beat, final_beat, abort_fin;
`ifdef BPFCAP_IRQ_EN
  logic irq_en_q;
`endif

  function automatic logic [BURST_W-1:0] burst_len(input logic [31:0] left);
    return (left >= MAX_BURST) ? BURST_W'(MAX_BURST) : BURST_W'(left);
  endfunction

  assign csr_ctrl_wr  = avs_s0_write && (avs_s0_address == 3'd0);
  assign cfg_wr       = avs_s0_write && !busy_q;
  assign start        = csr_ctrl_wr && avs_s0_writedata[0] && !busy_q;
  assign abort_req    = csr_ctrl_wr && avs_s0_writedata[1] && busy_q;
  assign misaligned   = |((src_q | dst_q | len_q) & AlignMask);
  assign rd_burst_nxt = burst_len(rd_left_q);
  assign wr_burst_nxt = burst_len(wr_left_q);
  // Only request what the FIFO is guaranteed to absorb, counting beats still in flight.
  assign rd_credit_ok = (32'(fifo_cnt_q) + 32'(rd_pend_q) + 32'(rd_burst_nxt)) <= FIFO_DEPTH;
  assign rd_accept    = (rd_state_q == RdReq) && !avs_m0_waitrequest;
  assign rd_beat      = avs_m0_readdatavalid && (rd_pend_q != '0);
  assign push         = rd_beat && !abort_q;
  assign beat_acc     = (wr_state_q == WrBurst) && !avs_m1_waitrequest;
  assign pop          = beat_acc && (fifo_cnt_q != '0);
  assign last_beat    = beat_acc && (wr_cnt_q == wr_burst_q - BURST_W'(1));
  assign final_beat   = last_beat && (wr_left_q == 32'(wr_burst_q));
  assign abort_fin    = abort_q && (wr_state_q != WrBurst) && (rd_state_q == RdIdle)
                        && (rd_pend_q == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_state_q <= RdIdle;
      wr_state_q <= WrIdle;
    end else begin
      rd_state_q <= rd_state_d;
      wr_state_q <= wr_state_d;
    end
  end

  always_comb begin
    rd_state_d = rd_state_q;
    case (rd_state_q)
      RdIdle: if (busy_q && !abort_q && (rd_left_q != '0) && rd_credit_ok) rd_state_d = RdReq;
      RdReq:  if (!avs_m0_waitrequest) rd_state_d = RdData;
      RdData: if (rd_beat && (rd_pend_q == BURST_W'(1))) rd_state_d = RdIdle;
      default: rd_state_d = RdIdle;
    endcase
  end

  always_comb begin
    wr_state_d = wr_state_q;
    case (wr_state_q)
      WrIdle: begin
        if (busy_q && !abort_q && (wr_left_q != '0) && (32'(fifo_cnt_q) >= 32'(wr_burst_nxt))) begin
          wr_state_d = WrBurst;
        end
      end
      WrBurst: if (last_beat) wr_state_d = final_beat ? WrDone : WrIdle;
      WrDone:  wr_state_d = WrIdle;
      default: wr_state_d = WrIdle;
    endcase
  end

  always_comb begin
    avs_m0_read       = (rd_state_q == RdReq);
    avs_m0_address    = rd_addr_q;
    avs_m0_burstcount = rd_burst_q;
    avs_m1_write      = (wr_state_q == WrBurst);
    avs_m1_address    = wr_addr_q;
    avs_m1_burstcount = wr_burst_q;
    // An aborted burst that drained the FIFO pads with zeros.
    avs_m1_writedata  = (fifo_cnt_q != '0) ? fifo_mem[fifo_rptr_q] : '0;
    avs_s0_readdata   = readdata_q;
  end

  always_comb begin
    csr_rdata = '0;
    case (avs_s0_address)
      3'd1: csr_rdata = src_q;
      3'd2: csr_rdata = dst_q;
      3'd3: csr_rdata = len_q;
      3'd4: csr_rdata = {28'd0, aborted_q, err_q, done_q, busy_q};
      3'd5: csr_rdata = pkt_count_q;
`ifdef BPFCAP_IRQ_EN
      3'd6: csr_rdata = {31'd0, irq_en_q};
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[fifo_wptr_q] <= avs_m0_readdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      src_q <= '0; dst_q <= '0; len_q <= '0; pkt_count_q <= '0; readdata_q <= '0;
      busy_q <= 1'b0; done_q <= 1'b0; err_q <= 1'b0; aborted_q <= 1'b0; abort_q <= 1'b0;
      rd_addr_q <= '0; rd_left_q <= '0; wr_addr_q <= '0; wr_left_q <= '0;
      rd_burst_q <= '0; rd_pend_q <= '0; wr_burst_q <= '0; wr_cnt_q <= '0;
      fifo_wptr_q <= '0; fifo_rptr_q <= '0; fifo_cnt_q <= '0;
    end else begin
      if (cfg_wr) begin
        case (avs_s0_address)
          3'd1: src_q <= avs_s0_writedata;
          3'd2: dst_q <= avs_s0_writedata;
          3'd3: len_q <= avs_s0_writedata;
          default: ;
        endcase
      end
      if (avs_s0_write && (avs_s0_address == 3'd4)) begin
        if (avs_s0_writedata[1]) done_q    <= 1'b0;
        if (avs_s0_writedata[2]) err_q     <= 1'b0;
        if (avs_s0_writedata[3]) aborted_q <= 1'b0;
      end
      if (avs_s0_read) readdata_q <= csr_rdata;
      if (start) begin
        if (len_q == '0) begin
          done_q <= 1'b1;
        end else if (misaligned) begin
          err_q <= 1'b1;
        end else begin
          busy_q    <= 1'b1;
          rd_addr_q <= src_q;
          wr_addr_q <= dst_q;
          rd_left_q <= len_q >> BpbLog;
          wr_left_q <= len_q >> BpbLog;
        end
      end
      if (abort_req) abort_q <= 1'b1;
      if ((rd_state_q == RdIdle) && (rd_state_d == RdReq)) rd_burst_q <= rd_burst_nxt;
      if (rd_accept) begin
        rd_pend_q <= rd_burst_q;
        rd_left_q <= rd_left_q - 32'(rd_burst_q);
        rd_addr_q <= rd_addr_q + (32'(rd_burst_q) << BpbLog);
      end else if (rd_beat) begin
        rd_pend_q <= rd_pend_q - BURST_W'(1);
      end
      if ((wr_state_q == WrIdle) && (wr_state_d == WrBurst)) begin
        wr_burst_q <= wr_burst_nxt;
        wr_cnt_q   <= '0;
      end else if (beat_acc) begin
        wr_cnt_q <= wr_cnt_q + BURST_W'(1);
      end
      if (last_beat) begin
        wr_left_q <= wr_left_q - 32'(wr_burst_q);
        wr_addr_q <= wr_addr_q + (32'(wr_burst_q) << BpbLog);
      end
      if (final_beat) begin
        busy_q      <= 1'b0;
        done_q      <= 1'b1;
        abort_q     <= 1'b0;
        pkt_count_q <= pkt_count_q + 32'd1;
      end
      if (push) fifo_wptr_q <= fifo_wptr_q + PtrW'(1);
      if (pop)  fifo_rptr_q <= fifo_rptr_q + PtrW'(1);
      if (push && !pop)      fifo_cnt_q <= fifo_cnt_q + (PtrW + 1)'(1);
      else if (!push && pop) fifo_cnt_q <= fifo_cnt_q - (PtrW + 1)'(1);
      if (abort_fin) begin
        busy_q      <= 1'b0;
        aborted_q   <= 1'b1;
        abort_q     <= 1'b0;
        fifo_wptr_q <= '0;
        fifo_rptr_q <= '0;
        fifo_cnt_q  <= '0;
      end
    end
  end

`ifdef BPFCAP_IRQ_EN
  always_ff @(posedge clk) begin
    if (reset) irq_en_q <= 1'b0;
    else if (avs_s0_write && (avs_s0_address == 3'd6)) irq_en_q <= avs_s0_writedata[0];
  end
  assign irq = irq_en_q & (done_q | err_q | aborted_q);
`else
  assign irq = 1'b0;
`endif

  fifo_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(push && (fifo_cnt_q == FifoFull)));
endmodule

// File: tb/tb_bpfcap_dma_engine.sv
// Directed bench for bpfcap_dma_engine with behavioural SDRAM read and write slaves.
module tb_bpfcap_dma_engine;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned BURST_W = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [2:0]         s0_address;
  logic               s0_write, s0_read;
  logic [31:0]        s0_writedata, s0_readdata;
  logic [31:0]        m0_address, m1_address;
  logic               m0_read, m1_write;
  logic [BURST_W-1:0] m0_burstcount, m1_burstcount;
  logic [DATA_W-1:0]  m0_readdata, m1_writedata;
  logic               m0_readdatavalid, m0_waitrequest, m1_waitrequest, irq;

  bpfcap_dma_engine dut (
    .clk                  (clk),
    .reset                (reset),
    .avs_s0_address       (s0_address),
    .avs_s0_write         (s0_write),
    .avs_s0_read          (s0_read),
    .avs_s0_writedata     (s0_writedata),
    .avs_s0_readdata      (s0_readdata),
    .avs_m0_address       (m0_address),
    .avs_m0_read          (m0_read),
    .avs_m0_burstcount    (m0_burstcount),
    .avs_m0_readdata      (m0_readdata),
    .avs_m0_readdatavalid (m0_readdatavalid),
    .avs_m0_waitrequest   (m0_waitrequest),
    .avs_m1_address       (m1_address),
    .avs_m1_write         (m1_write),
    .avs_m1_writedata     (m1_writedata),
    .avs_m1_burstcount    (m1_burstcount),
    .avs_m1_waitrequest   (m1_waitrequest),
    .irq                  (irq)
  );

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Slave-side state, owned by the negedge process below.
  bit          stall_en = 1'b0;
  bit          slave_flush = 1'b0;
  logic [31:0] rd_q [$];
  logic [31:0] dmem [1024];
  int          rd_bursts, wr_bursts, wr_beats, bus_cycles, viol, wr_idx;
  logic [31:0] last_rd_bc, last_wr_bc, last_wr_addr, wr_base, wr_bc_cur;
  logic        prev_rd_stall, prev_wr_stall;
  logic [31:0] prev_rd_addr, prev_wr_addr;
  logic [BURST_W-1:0] prev_rd_bc, prev_wr_bc;

  // Source memory returns ~address; writes into 0x8000..0x8FFF land in dmem.
  always @(negedge clk) begin
    m0_waitrequest = stall_en ? 1'($urandom_range(0, 1)) : 1'b0;
    m1_waitrequest = stall_en ? 1'($urandom_range(0, 1)) : 1'b0;
    if (reset || slave_flush) begin
      rd_q.delete();
      m0_readdatavalid = 1'b0;
      m0_readdata = '0;
      wr_idx = 0;
      prev_rd_stall = 1'b0;
      prev_wr_stall = 1'b0;
      rd_bursts = 0; wr_bursts = 0; wr_beats = 0; bus_cycles = 0;
      last_rd_bc = '0; last_wr_bc = '0; last_wr_addr = '0;
      if (slave_flush) for (int i = 0; i < 1024; i++) dmem[i] = 32'hDEAD_BEEF;
    end else begin
      if (rd_q.size() != 0) begin
        m0_readdatavalid = 1'b1;
        m0_readdata = ~rd_q.pop_front();
      end else begin
        m0_readdatavalid = 1'b0;
        m0_readdata = '0;
      end
      if (prev_rd_stall && (m0_read !== 1'b1 || m0_address !== prev_rd_addr ||
                            m0_burstcount !== prev_rd_bc)) viol++;
      prev_rd_stall = (m0_read === 1'b1) && m0_waitrequest;
      prev_rd_addr  = m0_address;
      prev_rd_bc    = m0_burstcount;
      if (m0_read === 1'b1 && !m0_waitrequest) begin
        rd_bursts++;
        last_rd_bc = 32'(m0_burstcount);
        for (int i = 0; i < int'(m0_burstcount); i++) rd_q.push_back(m0_address + 32'(4 * i));
      end
      if (m0_read === 1'b1 || m1_write === 1'b1) bus_cycles++;
      if (prev_wr_stall && (m1_write !== 1'b1 || m1_address !== prev_wr_addr ||
                            m1_burstcount !== prev_wr_bc)) viol++;
      prev_wr_stall = (m1_write === 1'b1) && m1_waitrequest;
      prev_wr_addr  = m1_address;
      prev_wr_bc    = m1_burstcount;
      if (m1_write === 1'b1 && !m1_waitrequest) begin
        if (wr_idx == 0) begin
          wr_bursts++;
          wr_base = m1_address;
          wr_bc_cur = 32'(m1_burstcount);
          last_wr_bc = 32'(m1_burstcount);
          last_wr_addr = m1_address;
        end else if (m1_address !== wr_base || 32'(m1_burstcount) !== wr_bc_cur) begin
          viol++;
        end
        if ((wr_base + 32'(4 * wr_idx)) >= 32'h8000 && (wr_base + 32'(4 * wr_idx)) < 32'h9000)
          dmem[(wr_base + 32'(4 * wr_idx) - 32'h8000) >> 2] = m1_writedata;
        wr_beats++;
        wr_idx++;
        if (wr_idx == int'(wr_bc_cur)) wr_idx = 0;
      end
    end
  end

  task automatic csr_wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    s0_address = a; s0_writedata = d; s0_write = 1'b1;
    @(negedge clk);
    s0_write = 1'b0;
  endtask

  task automatic csr_rd(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    s0_address = a; s0_read = 1'b1;
    @(negedge clk);
    s0_read = 1'b0;
    d = s0_readdata;
  endtask

  task automatic flush_slaves();
    @(negedge clk); slave_flush = 1'b1;
    @(negedge clk); slave_flush = 1'b0;
  endtask

  task automatic run(input logic [31:0] src, input logic [31:0] dst, input logic [31:0] len);
    csr_wr(3'd1, src);
    csr_wr(3'd2, dst);
    csr_wr(3'd3, len);
    csr_wr(3'd0, 32'h1);
  endtask

  task automatic wait_idle(input string tag);
    logic [31:0] st;
    int n;
    st = 32'h1;
    n = 0;
    while (st[0] && n < 10000) begin
      csr_rd(3'd4, st);
      n++;
    end
    check_eq({tag, "_idle"}, {31'd0, st[0]}, 32'd0);
  endtask

  task automatic check_data(input string tag, input logic [31:0] src, input int words);
    int bad;
    bad = 0;
    for (int i = 0; i < words; i++) if (dmem[i] !== ~(src + 32'(4 * i))) bad++;
    check_eq(tag, 32'(bad), 32'd0);
  endtask

  logic [31:0] d;
  int g;

  initial begin
    s0_address = '0; s0_write = 1'b0; s0_read = 1'b0; s0_writedata = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_m0_read", {31'd0, m0_read}, 32'd0);
    check_eq("rst_m1_write", {31'd0, m1_write}, 32'd0);
    check_eq("rst_irq", {31'd0, irq}, 32'd0);
    reset = 1'b0;
    csr_rd(3'd4, d); check_eq("rst_status", d, 32'd0);
    csr_rd(3'd5, d); check_eq("rst_pkt", d, 32'd0);
    csr_rd(3'd1, d); check_eq("rst_src", d, 32'd0);

    // 64 bytes, one burst each way
    flush_slaves();
    run(32'h1000, 32'h8000, 32'd64);
    wait_idle("t64");
    csr_rd(3'd4, d); check_eq("t64_status", d, 32'h2);
    csr_rd(3'd5, d); check_eq("t64_pkt", d, 32'd1);
    check_eq("t64_rd_bursts", 32'(rd_bursts), 32'd1);
    check_eq("t64_wr_bursts", 32'(wr_bursts), 32'd1);
    check_eq("t64_rd_bc", last_rd_bc, 32'd16);
    check_eq("t64_wr_bc", last_wr_bc, 32'd16);
    check_data("t64_data", 32'h1000, 16);
    csr_wr(3'd4, 32'h2);
    csr_rd(3'd4, d); check_eq("t64_w1c", d, 32'd0);

    // 100 bytes = 25 beats -> 16 + 9
    flush_slaves();
    run(32'h1000, 32'h8000, 32'd100);
    wait_idle("t100");
    check_eq("t100_rd_bursts", 32'(rd_bursts), 32'd2);
    check_eq("t100_rd_bc", last_rd_bc, 32'd9);
    check_eq("t100_wr_bursts", 32'(wr_bursts), 32'd2);
    check_eq("t100_wr_bc", last_wr_bc, 32'd9);
    check_eq("t100_wr_addr", last_wr_addr, 32'h8040);
    check_data("t100_data", 32'h1000, 25);
    csr_rd(3'd5, d); check_eq("t100_pkt", d, 32'd2);
    csr_wr(3'd4, 32'h2);

    // 4096 bytes with random stalls on both masters
    stall_en = 1'b1;
    flush_slaves();
    run(32'h2000, 32'h8000, 32'd4096);
    wait_idle("tstall");
    stall_en = 1'b0;
    check_data("tstall_data", 32'h2000, 1024);
    check_eq("tstall_rd_bursts", 32'(rd_bursts), 32'd64);
    check_eq("tstall_wr_bursts", 32'(wr_bursts), 32'd64);
    check_eq("tstall_stable", 32'(viol), 32'd0);
    csr_rd(3'd5, d); check_eq("tstall_pkt", d, 32'd3);
    csr_rd(3'd4, d); check_eq("tstall_status", d, 32'h2);
    csr_wr(3'd4, 32'h2);

    // Misaligned length
    flush_slaves();
    run(32'h1000, 32'h8000, 32'd6);
    repeat (5) @(negedge clk);
    csr_rd(3'd4, d); check_eq("tlen6_status", d, 32'h4);
    check_eq("tlen6_traffic", 32'(bus_cycles), 32'd0);
    csr_wr(3'd4, 32'h4);

    // Zero length
    flush_slaves();
    run(32'h1000, 32'h8000, 32'd0);
    csr_rd(3'd4, d); check_eq("tlen0_status", d, 32'h2);
    check_eq("tlen0_traffic", 32'(bus_cycles), 32'd0);
    csr_rd(3'd5, d); check_eq("tlen0_pkt", d, 32'd3);
    csr_wr(3'd4, 32'h2);

    // Abort around write beat 20 of 64
    flush_slaves();
    run(32'h1000, 32'h8000, 32'd256);
    g = 0;
    while (wr_beats < 20 && g < 2000) begin @(negedge clk); g++; end
    check_eq("tab_reach20", {31'd0, wr_beats >= 20}, 32'd1);
    csr_wr(3'd0, 32'h2);
    wait_idle("tab");
    csr_rd(3'd4, d); check_eq("tab_status", d, 32'h8);
    csr_rd(3'd5, d); check_eq("tab_pkt", d, 32'd3);
    check_eq("tab_whole_bursts", 32'(wr_beats % 16), 32'd0);
    check_eq("tab_stopped_early", {31'd0, wr_beats < 64}, 32'd1);
    check_eq("tab_rd_drained", 32'(rd_q.size()), 32'd0);
    csr_wr(3'd4, 32'h8);

    // A clean transfer afterwards only matches if the FIFO was flushed
    flush_slaves();
    run(32'h3000, 32'h8000, 32'd64);
    wait_idle("tpost");
    check_data("tpost_data", 32'h3000, 16);
    csr_rd(3'd5, d); check_eq("tpost_pkt", d, 32'd4);
    csr_wr(3'd4, 32'h2);

`ifdef BPFCAP_IRQ_EN
    csr_wr(3'd6, 32'h1);
    csr_rd(3'd6, d); check_eq("irq_en_rd", d, 32'd1);
    run(32'h1000, 32'h8000, 32'd0);
    check_eq("irq_done", {31'd0, irq}, 32'd1);
    csr_wr(3'd4, 32'h2);
    check_eq("irq_w1c", {31'd0, irq}, 32'd0);
`else
    csr_wr(3'd6, 32'h1);
    csr_rd(3'd6, d); check_eq("irq_en_rd", d, 32'd0);
    run(32'h1000, 32'h8000, 32'd0);
    check_eq("irq_tied", {31'd0, irq}, 32'd0);
    csr_wr(3'd4, 32'h2);
`endif

    // Reset in the middle of a transfer
    flush_slaves();
    run(32'h1000, 32'h8000, 32'd256);
    g = 0;
    while (!(m1_write === 1'b1) && g < 2000) begin @(negedge clk); g++; end
    check_eq("trst_active", {31'd0, m1_write}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check_eq("trst_m0_read", {31'd0, m0_read}, 32'd0);
    check_eq("trst_m1_write", {31'd0, m1_write}, 32'd0);
    check_eq("trst_m1_addr", m1_address, 32'd0);
    check_eq("trst_m0_bc", 32'(m0_burstcount), 32'd0);
    check_eq("trst_irq", {31'd0, irq}, 32'd0);
    reset = 1'b0;
    csr_rd(3'd4, d); check_eq("trst_status", d, 32'd0);
    csr_rd(3'd5, d); check_eq("trst_pkt", d, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
